// File: rtl/adder_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_bist_pkg
// Brief  : Shared types, deterministic vectors and polynomial taps for the
//          16-bit adder BIST sequencer.
// Rev    : 1.0
// ============================================================================
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DET   = 3'd1,
        PRPG  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Fibonacci taps for x^32+x^22+x^2+x+1 and x^17+x^14+1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [16:0] MISR_TAPS = 17'h1_2000;

    localparam logic [3:0]  FAIL_SIG  = 4'h8;
    localparam logic [3:0]  FAIL_NONE = 4'hF;
    localparam logic [2:0]  DET_LAST  = 3'd7;

    // {a, b, cin}
    function automatic logic [32:0] det_operands(input logic [2:0] idx);
        logic [32:0] v;
        case (idx)
            3'd0:    v = {16'h0000, 16'h0000, 1'b0};
            3'd1:    v = {16'h0000, 16'hFFFF, 1'b0};
            3'd2:    v = {16'h0000, 16'hFFFF, 1'b1};
            3'd3:    v = {16'hFFFF, 16'h0000, 1'b0};
            3'd4:    v = {16'hFFFF, 16'h0000, 1'b1};
            3'd5:    v = {16'hFFFF, 16'hFFFF, 1'b1};
            3'd6:    v = {16'h5555, 16'h5555, 1'b0};
            default: v = {16'hAAAA, 16'hAAAA, 1'b1};
        endcase
        return v;
    endfunction

    // {cout, sum}
    function automatic logic [16:0] det_expected(input logic [2:0] idx);
        logic [16:0] v;
        case (idx)
            3'd0:    v = {1'b0, 16'h0000};
            3'd1:    v = {1'b0, 16'hFFFF};
            3'd2:    v = {1'b1, 16'h0000};
            3'd3:    v = {1'b0, 16'hFFFF};
            3'd4:    v = {1'b1, 16'h0000};
            3'd5:    v = {1'b1, 16'hFFFF};
            3'd6:    v = {1'b0, 16'hAAAA};
            default: v = {1'b1, 16'h5555};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] lfsr);
        return {lfsr[30:0], ^(lfsr & LFSR_TAPS)};
    endfunction

    function automatic logic [32:0] prpg_operands(input logic [31:0] lfsr);
        return {lfsr, lfsr[31] ^ lfsr[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_bist_ctrl_misr.sv
`default_nettype none
// ============================================================================
// Module : bist_misr17
// Brief  : 17-bit multiple-input signature register with clear and enable.
// Rev    : 1.0
// ============================================================================
module bist_misr17
    import adder_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [16:0] i_data,
    output logic [16:0] o_sig
);

    logic [16:0] r_misr;
    logic        w_fb;

    assign w_fb  = ^(r_misr & MISR_TAPS);
    assign o_sig = r_misr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_misr <= '0;
        end else if (i_clr) begin
            r_misr <= '0;
        end else if (i_en) begin
            r_misr <= {r_misr[15:0], w_fb} ^ i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module : adder_bist_ctrl
// Brief  : BIST sequencer for adder16: deterministic vectors, then LFSR
//          patterns compacted into a MISR and compared with a golden signature.
// Rev    : 1.0
// ============================================================================
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          NUM_PATTERNS = 256,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bist_en,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    input  logic [16:0]      golden_sig,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_idx,
    output logic [16:0]      signature
);

    localparam logic [15:0] C_LAST_PAT = 16'(NUM_PATTERNS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [2:0]       r_vec_cnt;
    logic [15:0]      r_pat_cnt;
    logic [31:0]      r_lfsr;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_fail_idx;

    logic [16:0]      w_resp;
    logic [16:0]      w_sig;
    logic             w_launch;
    logic             w_misr_en;

    assign w_resp    = {adder_cout, adder_sum};
    assign w_launch  = bist_en && start && (r_state == IDLE || r_state == DONE);
    assign w_misr_en = bist_en && (r_state == PRPG);

    bist_misr17 u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_launch),
        .i_en   (w_misr_en),
        .i_data (w_resp),
        .o_sig  (w_sig)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_vec_cnt  <= '0;
            r_pat_cnt  <= '0;
            r_lfsr     <= LFSR_SEED;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_idx <= FAIL_NONE;
        end else if (!bist_en) begin
            r_state <= IDLE;
            {r_a, r_b, r_cin} <= {x, y, c0};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= DET;
                        {r_a, r_b, r_cin} <= det_operands(3'd0);
                        r_vec_cnt  <= '0;
                        r_lfsr     <= LFSR_SEED;
                        r_fail_idx <= FAIL_NONE;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end else begin
                        {r_a, r_b, r_cin} <= {x, y, c0};
                    end
                end
                DET: begin
                    // Only the first failing vector is recorded; the run continues.
                    if (w_resp != det_expected(r_vec_cnt) && r_fail_idx == FAIL_NONE) begin
                        r_fail_idx <= {1'b0, r_vec_cnt};
                    end
                    if (r_vec_cnt == DET_LAST) begin
                        r_state   <= PRPG;
                        {r_a, r_b, r_cin} <= prpg_operands(r_lfsr);
                        r_lfsr    <= lfsr_step(r_lfsr);
                        r_pat_cnt <= '0;
                    end else begin
                        r_vec_cnt <= r_vec_cnt + 3'd1;
                        {r_a, r_b, r_cin} <= det_operands(r_vec_cnt + 3'd1);
                    end
                end
                PRPG: begin
                    {r_a, r_b, r_cin} <= prpg_operands(r_lfsr);
                    r_lfsr <= lfsr_step(r_lfsr);
                    if (r_pat_cnt == C_LAST_PAT) begin
                        r_state <= CHECK;
                    end else begin
                        r_pat_cnt <= r_pat_cnt + 16'd1;
                    end
                end
                CHECK: begin
                    if (w_sig != golden_sig && r_fail_idx == FAIL_NONE) begin
                        r_fail_idx <= FAIL_SIG;
                    end
                    r_pass  <= (r_fail_idx == FAIL_NONE) && (w_sig == golden_sig);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign adder_a   = r_a;
    assign adder_b   = r_b;
    assign adder_cin = r_cin;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_idx  = r_fail_idx;
    assign signature = w_sig;

endmodule
`default_nettype wire

// File: tb/tb_adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_adder_bist_ctrl
// Brief  : Scoreboard bench for adder_bist_ctrl with a behavioural adder16.
// Rev    : 1.0
// ============================================================================
module tb_adder_bist_ctrl;

    localparam int N_PAT = 4;

    typedef struct packed {
        logic        pass;
        logic [3:0]  fidx;
        logic [16:0] sig;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        bist_en;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        c0;
    logic [16:0] golden_sig;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic        adder_cin;
    logic [15:0] adder_sum;
    logic        adder_cout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  fail_idx;
    logic [16:0] signature;

    logic        fault_sa0 = 1'b0;
    logic [16:0] w_add;
    logic [31:0] cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q[$];
    logic [16:0] good_sig;
    logic [16:0] bad_sig;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder16 with optional sum bit0 stuck-at-0
    assign w_add      = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};
    assign adder_sum  = fault_sa0 ? {w_add[15:1], 1'b0} : w_add[15:0];
    assign adder_cout = w_add[16];

    adder_bist_ctrl #(
        .WIDTH        (16),
        .NUM_PATTERNS (N_PAT),
        .LFSR_SEED    (32'hACE1_0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bist_en    (bist_en),
        .start      (start),
        .x          (x),
        .y          (y),
        .c0         (c0),
        .golden_sig (golden_sig),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_idx   (fail_idx),
        .signature  (signature)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference signature: step LFSR, add, compact, for n patterns
    function automatic logic [16:0] model_sig(input int n, input bit sa0);
        logic [31:0] l = 32'hACE1_0001;
        logic [16:0] m = '0;
        logic [16:0] r;
        for (int k = 0; k < n; k++) begin
            r = {1'b0, l[31:16]} + {1'b0, l[15:0]} + {16'd0, l[31] ^ l[0]};
            if (sa0) r[0] = 1'b0;
            m = {m[15:0], m[16] ^ m[13]} ^ r;
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        return m;
    endfunction

    // Pulse start for one cycle; optionally queue the verdict the run must end with
    task automatic launch(input bit push, input logic p, input logic [3:0] f, input logic [16:0] s);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        if (push) begin
            e.pass = p;
            e.fidx = f;
            e.sig  = s;
            e.cyc  = cyc + 32'd14;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", max_cyc);
        end
        @(negedge clk);
    endtask

    // Monitor: every rising done must match the oldest queued expectation
    initial begin
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("pass", {31'd0, pass}, {31'd0, e.pass});
                    chk("fail_idx", {28'd0, fail_idx}, {28'd0, e.fidx});
                    chk("signature", {15'd0, signature}, {15'd0, e.sig});
                    chk("busy_in_done", {31'd0, busy}, 32'd0);
                end
            end
            done_q = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        good_sig   = model_sig(N_PAT, 1'b0);
        bad_sig    = model_sig(N_PAT, 1'b1);
        rst        = 1'b0;
        bist_en    = 1'b0;
        start      = 1'b0;
        x          = '0;
        y          = '0;
        c0         = 1'b0;
        golden_sig = good_sig;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_adder_a", {16'd0, adder_a}, 32'd0);
        chk("rst_adder_cin", {31'd0, adder_cin}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_fail_idx", {28'd0, fail_idx}, 32'hF);
        chk("rst_signature", {15'd0, signature}, 32'd0);

        // Functional mode passes operands through one cycle later
        rst = 1'b1;
        x   = 16'h1234;
        y   = 16'h0001;
        c0  = 1'b1;
        @(negedge clk);
        chk("func_adder_a", {16'd0, adder_a}, 32'h1234);
        chk("func_adder_b", {16'd0, adder_b}, 32'h0001);
        chk("func_adder_cin", {31'd0, adder_cin}, 32'd1);
        chk("func_busy", {31'd0, busy}, 32'd0);
        chk("func_done", {31'd0, done}, 32'd0);

        // Good adder, matching golden signature
        bist_en = 1'b1;
        launch(1'b1, 1'b1, 4'hF, good_sig);
        wait_done(30);
        repeat (3) @(negedge clk);
        chk("sig_frozen", {15'd0, signature}, {15'd0, good_sig});
        x = 16'hBEEF;
        @(negedge clk);
        chk("done_func_adder_a", {16'd0, adder_a}, 32'hBEEF);

        // Sum bit0 stuck-at-0: vector 1 is the first to miss
        fault_sa0 = 1'b1;
        launch(1'b1, 1'b0, 4'h1, bad_sig);
        wait_done(30);
        fault_sa0 = 1'b0;

        // Golden signature off by one bit
        golden_sig = good_sig ^ 17'h1;
        launch(1'b1, 1'b0, 4'h8, good_sig);
        wait_done(30);
        golden_sig = good_sig;

        // Abort during PRPG cycle 2, then a clean rerun
        launch(1'b0, 1'b0, 4'h0, 17'h0);
        repeat (10) @(negedge clk);
        bist_en = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        bist_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_done", {31'd0, done}, 32'd0);
        launch(1'b1, 1'b1, 4'hF, good_sig);
        wait_done(30);

        // start during PRPG ignored; start in DONE restarts
        launch(1'b1, 1'b1, 4'hF, good_sig);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("prpg_start_busy", {31'd0, busy}, 32'd1);
        wait_done(30);
        launch(1'b1, 1'b1, 4'hF, good_sig);
        wait_done(30);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
